// File: rtl/frame_rx_deserializer.sv
// Serial frame receiver: hunts for the start delimiter, deserializes 12 bits, filters on
// destination address and keeps saturating accept/drop counters.
module frame_rx_deserializer #(
  parameter logic [3:0] MAC_ADDRESS = 4'hA,
  parameter logic [3:0] SFD         = 4'b0101,
  parameter logic [3:0] BCAST_ADDR  = 4'hF,
  parameter bit         PROMISC     = 1'b0,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_bit,
  input  logic             abort,
  input  logic             cnt_clr,
  output logic [15:0]      rx_frame,
  output logic             frame_rx_valid,
  output logic             rx_busy,
  output logic [CNT_W-1:0] rx_ok_count,
  output logic [CNT_W-1:0] rx_drop_count
);

  typedef enum logic [1:0] {HUNT, CAPTURE, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [3:0]  hunt_sr;
  logic [11:0] cap_sr;
  logic [3:0]  bit_cnt;
  logic [3:0]  dst;
  logic        accept;
  logic        sfd_hit;

  assign dst     = cap_sr[11:8];
  assign accept  = PROMISC || (dst == MAC_ADDRESS) || (dst == BCAST_ADDR);
  assign sfd_hit = ({hunt_sr[2:0], rx_bit} == SFD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      hunt_sr        <= 4'b0;
      cap_sr         <= 12'h0;
      bit_cnt        <= 4'd0;
      rx_frame       <= 16'h0;
      frame_rx_valid <= 1'b0;
      rx_busy        <= 1'b0;
    end else begin
      frame_rx_valid <= 1'b0;
      if (abort) begin
        state   <= HUNT;
        hunt_sr <= 4'b0;
        bit_cnt <= 4'd0;
        rx_busy <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            hunt_sr <= {hunt_sr[2:0], rx_bit};
            if (sfd_hit) begin
              state   <= CAPTURE;
              bit_cnt <= 4'd0;
              rx_busy <= 1'b1;
            end
          end
          CAPTURE: begin
            cap_sr  <= {cap_sr[10:0], rx_bit};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd11) state <= CHECK;
          end
          CHECK: begin
            if (accept) begin
              rx_frame       <= {SFD, cap_sr};
              frame_rx_valid <= 1'b1;
            end
            // the bit arriving now may already be the first SFD bit of the next frame
            hunt_sr <= {3'b000, rx_bit};
            state   <= HUNT;
            rx_busy <= 1'b0;
          end
          default: begin
            state   <= HUNT;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ok_count   <= '0;
      rx_drop_count <= '0;
    end else if (cnt_clr) begin
      rx_ok_count   <= '0;
      rx_drop_count <= '0;
    end else if (state == CHECK && !abort) begin
      if (accept) begin
        if (rx_ok_count != CNT_MAX) rx_ok_count <= rx_ok_count + 1'b1;
      end else if (rx_drop_count != CNT_MAX) begin
        rx_drop_count <= rx_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_rx_deserializer.sv
// Directed bench for frame_rx_deserializer: serializes frames MSB-first on the falling edge
// and checks outputs against hand-computed values.
module tb_frame_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_bit = 1'b0;
  logic        abort = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] rx_frame;
  logic        frame_rx_valid;
  logic        rx_busy;
  logic [7:0]  rx_ok_count;
  logic [7:0]  rx_drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe = -1;
  int prev_strobe = -1;
  int dbl = 0;
  int last_bit_k = 0;
  int s0;
  logic prev_v = 1'b0;

  frame_rx_deserializer dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .abort(abort), .cnt_clr(cnt_clr),
    .rx_frame(rx_frame), .frame_rx_valid(frame_rx_valid), .rx_busy(rx_busy),
    .rx_ok_count(rx_ok_count), .rx_drop_count(rx_drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_rx_valid) begin
        if (prev_v) dbl++;
        strobe_cnt++;
        prev_strobe = last_strobe;
        last_strobe = cyc;
      end
      prev_v = frame_rx_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_bit = b;
  endtask

  task automatic send_frame(input logic [15:0] f);
    for (int i = 15; i >= 0; i--) begin
      send_bit(f[i]);
      if (i == 0) last_bit_k = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  initial begin
    logic [15:0] part;
    #12;
    check("rst_frame", rx_frame, 16'h0);
    check("rst_valid", frame_rx_valid, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_ok", rx_ok_count, 8'd0);
    check("rst_drop", rx_drop_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // own address
    s0 = strobe_cnt;
    send_frame(16'h5AB3);
    idle(3);
    check("acc_strobes", strobe_cnt - s0, 1);
    check("acc_latency", last_strobe, last_bit_k + 1);
    check("acc_frame", rx_frame, 16'h5AB3);
    check("acc_ok", rx_ok_count, 8'd1);

    // foreign address
    s0 = strobe_cnt;
    send_frame(16'h5CB3);
    idle(3);
    check("drop_strobes", strobe_cnt - s0, 0);
    check("drop_frame", rx_frame, 16'h5AB3);
    check("drop_cnt", rx_drop_count, 8'd1);
    check("drop_ok", rx_ok_count, 8'd1);

    // broadcast, then the next frame right after the CHECK cycle
    s0 = strobe_cnt;
    send_frame(16'h5FD7);
    idle(1);
    send_frame(16'h5A15);
    idle(3);
    check("b2b_strobes", strobe_cnt - s0, 2);
    check("b2b_gap", last_strobe - prev_strobe, 17);
    check("b2b_frame", rx_frame, 16'h5A15);
    check("b2b_ok", rx_ok_count, 8'd3);

    // SFD pattern inside payload
    s0 = strobe_cnt;
    send_frame(16'h5A55);
    idle(20);
    check("sfd_in_data_strobes", strobe_cnt - s0, 1);
    check("sfd_in_data_frame", rx_frame, 16'h5A55);
    check("sfd_in_data_ok", rx_ok_count, 8'd4);

    // abort after 6 capture bits
    s0 = strobe_cnt;
    part = 16'h5AB3;
    for (int i = 15; i >= 6; i--) send_bit(part[i]);
    @(negedge clk);
    check("abort_busy_before", rx_busy, 1'b1);
    abort = 1'b1;
    rx_bit = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_after", rx_busy, 1'b0);
    idle(20);
    check("abort_strobes", strobe_cnt - s0, 0);
    check("abort_ok", rx_ok_count, 8'd4);
    check("abort_drop", rx_drop_count, 8'd1);
    send_frame(16'h5AB3);
    idle(3);
    check("post_abort_strobes", strobe_cnt - s0, 1);
    check("post_abort_ok", rx_ok_count, 8'd5);

    // saturation
    for (int n = 0; n < 250; n++) begin
      send_frame(16'h5AB3);
      idle(1);
    end
    idle(2);
    check("sat_reach", rx_ok_count, 8'hFF);
    send_frame(16'h5AB3);
    idle(3);
    check("sat_hold", rx_ok_count, 8'hFF);
    check("no_double_strobe", dbl, 0);

    // clear coinciding with an accept
    s0 = strobe_cnt;
    send_frame(16'h5AB3);
    @(negedge clk);
    rx_bit  = 1'b0;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    idle(2);
    check("clr_strobe", strobe_cnt - s0, 1);
    check("clr_ok", rx_ok_count, 8'd0);
    check("clr_drop", rx_drop_count, 8'd0);

    // reset in the middle of CAPTURE
    send_frame(16'h5A15);
    idle(3);
    check("pre_rst_ok", rx_ok_count, 8'd1);
    part = 16'h5AB3;
    for (int i = 15; i >= 8; i--) send_bit(part[i]);
    @(negedge clk);
    check("pre_rst_busy", rx_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_frame", rx_frame, 16'h0);
    check("mid_rst_busy", rx_busy, 1'b0);
    check("mid_rst_ok", rx_ok_count, 8'd0);
    check("mid_rst_valid", frame_rx_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    for (int i = 7; i >= 0; i--) send_bit(part[i]);
    idle(20);
    check("post_rst_no_frame", strobe_cnt - s0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
